// File: rtl/nonce_arb_pkg.sv
// Shared types and constants for the golden-nonce report arbiter.
// The default nonce width is defined here; the arbiter derives its own byte count from its parameter.
package nonce_arb_pkg;

  localparam int NONCE_W_DEFAULT = 32;
  localparam int NONCE_BYTES     = NONCE_W_DEFAULT / 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nonce_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr, wrapping modulo NUM_CORES.
module nonce_rr_pick
  import nonce_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 2
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic                 gnt_valid,
  output logic [PTR_W-1:0]     gnt_idx
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  // Scan from the farthest offset down, so the nearest request is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    idx       = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NUM_CORES)) begin
        sum = sum - (PTR_W + 1)'(NUM_CORES);
      end
      idx = sum[PTR_W-1:0];
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/nonce_report_arbiter.sv
// Holds one golden nonce per core and serializes them, LSB first, onto the byte-wide
// FIFO write port. Slots are granted round-robin. A new strobe on a slot that is still occupied is dropped and flagged.
module nonce_report_arbiter
  import nonce_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W   = NONCE_W_DEFAULT
) (
  input  logic                          hash_clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          core_new_nonce,
  input  logic [NUM_CORES*NONCE_W-1:0]  core_golden_nonce,
  input  logic                          fifo_full,
  output logic [7:0]                    fifo_data,
  output logic                          fifo_wr_en,
  output logic [NUM_CORES-1:0]          pending,
  output logic [NUM_CORES-1:0]          overflow,
  output logic                          busy
);

  localparam int BYTES = NONCE_W / 8;
  localparam int CNT_W = clog2(BYTES) + 1;
  localparam int PTR_W = clog2(NUM_CORES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [PTR_W-1:0] LAST_CORE = PTR_W'(NUM_CORES - 1);

  arb_state_t           state_reg, state_next;
  logic [NONCE_W-1:0]   shift_reg;
  logic [CNT_W-1:0]     byte_cnt_reg;
  logic [PTR_W-1:0]     rr_ptr_reg;
  logic [NUM_CORES-1:0] pending_reg;
  logic [NUM_CORES-1:0] overflow_reg;
  logic [NONCE_W-1:0]   hold_reg [NUM_CORES];

  logic                 gnt_valid;
  logic [PTR_W-1:0]     gnt_idx;
  logic                 grant;
  logic [NUM_CORES-1:0] slot_granted;
  logic [NUM_CORES-1:0] slot_load;
  logic [NUM_CORES-1:0] slot_drop;

  nonce_rr_pick #(
    .NUM_CORES (NUM_CORES),
    .PTR_W     (PTR_W)
  ) u_pick (
    .req       (pending_reg),
    .ptr       (rr_ptr_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // A slot being granted frees up in the same cycle, so a strobe arriving then reloads it.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_slot
    assign slot_granted[gi] = grant && (gnt_idx == PTR_W'(gi));
    assign slot_load[gi]    = core_new_nonce[gi] && (!pending_reg[gi] || slot_granted[gi]);
    assign slot_drop[gi]    = core_new_nonce[gi] && pending_reg[gi] && !slot_granted[gi];
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      pending_reg  <= '0;
      overflow_reg <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        hold_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (slot_load[i]) begin
          hold_reg[i] <= core_golden_nonce[i*NONCE_W +: NONCE_W];
        end
      end
      pending_reg  <= (pending_reg & ~slot_granted) | slot_load;
      overflow_reg <= overflow_reg | slot_drop;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant      = 1'b0;
    fifo_wr_en = 1'b0;
    fifo_data  = '0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gnt_valid) begin
          grant      = 1'b1;
          state_next = SEND;
        end
      end
      SEND: begin
        busy       = 1'b1;
        fifo_data  = shift_reg[7:0];
        fifo_wr_en = !fifo_full;
        if (!fifo_full && (byte_cnt_reg == LAST_BYTE)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      byte_cnt_reg <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (grant) begin
        shift_reg    <= hold_reg[gnt_idx];
        byte_cnt_reg <= '0;
        rr_ptr_reg   <= (gnt_idx == LAST_CORE) ? '0 : gnt_idx + PTR_W'(1);
      end else if (fifo_wr_en) begin
        shift_reg    <= shift_reg >> 8;
        byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign pending  = pending_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_nonce_report_arbiter.sv
// Self-checking bench for nonce_report_arbiter: expected bytes are queued when nonces are
// strobed and compared as the FIFO write port emits them.
module tb_nonce_report_arbiter;

  logic         hash_clk;
  logic         reset;
  logic [3:0]   core_new_nonce;
  logic [127:0] core_golden_nonce;
  logic         fifo_full;
  logic [7:0]   fifo_data;
  logic         fifo_wr_en;
  logic [3:0]   pending;
  logic [3:0]   overflow;
  logic         busy;

  nonce_report_arbiter #(
    .NUM_CORES (4),
    .NONCE_W   (32)
  ) dut (
    .hash_clk          (hash_clk),
    .reset             (reset),
    .core_new_nonce    (core_new_nonce),
    .core_golden_nonce (core_golden_nonce),
    .fifo_full         (fifo_full),
    .fifo_data         (fifo_data),
    .fifo_wr_en        (fifo_wr_en),
    .pending           (pending),
    .overflow          (overflow),
    .busy              (busy)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bytes_seen = 0;
  int strobe_cyc = 0;
  logic [7:0] sb[$];
  int cyc_q[$];

  always @(posedge hash_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Byte monitor: one compare per FIFO write.
  always @(negedge hash_clk) begin
    if (fifo_wr_en === 1'b1) begin
      logic [7:0] exp_b;
      bytes_seen++;
      cyc_q.push_back(cyc);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_byte: got %h, expected no write (cycle %0d)", fifo_data, cyc);
      end else begin
        exp_b = sb.pop_front();
        check("fifo_data", {24'h0, fifo_data}, {24'h0, exp_b});
      end
    end
  end

  function automatic logic [127:0] at(input int core, input logic [31:0] n);
    logic [127:0] v;
    v = '0;
    v[core*32 +: 32] = n;
    return v;
  endfunction

  task automatic push_nonce(input logic [31:0] n);
    for (int b = 0; b < 4; b++) sb.push_back(n[8*b +: 8]);
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [127:0] vec);
    @(posedge hash_clk); #1;
    core_new_nonce    = mask;
    core_golden_nonce = vec;
    strobe_cyc        = cyc;
    @(posedge hash_clk); #1;
    core_new_nonce    = '0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 300;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge hash_clk); #1;
      budget--;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_drain: got %0d bytes outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    @(posedge hash_clk); #1;
  endtask

  task automatic wait_bytes(input int target);
    int budget;
    budget = 100;
    while (bytes_seen < target && budget > 0) begin
      @(posedge hash_clk); #1;
      budget--;
    end
    if (bytes_seen < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_bytes: got %0d bytes, expected %0d", bytes_seen, target);
    end
  endtask

  task automatic check_timing(input string name, input int n, input int first_off, input int last_off);
    check({name, "_count"}, cyc_q.size(), n);
    if (cyc_q.size() == n) begin
      check({name, "_first_cyc"}, cyc_q[0] - strobe_cyc, first_off);
      check({name, "_last_cyc"}, cyc_q[n-1] - strobe_cyc, last_off);
    end
  endtask

  typedef struct {
    int          core;
    logic [31:0] nonce;
  } vec_t;

  vec_t vt[4];

  initial begin
    int base;
    int c;
    vt[0] = '{core: 1, nonce: 32'hDEADBEEF};
    vt[1] = '{core: 0, nonce: 32'h0123_4567};
    vt[2] = '{core: 3, nonce: 32'hFF00_80C3};
    vt[3] = '{core: 2, nonce: 32'h7E5A_0001};

    reset = 1'b1;
    core_new_nonce = '0;
    core_golden_nonce = '0;
    fifo_full = 1'b0;
    repeat (3) @(posedge hash_clk);
    #1;
    check("rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    check("rst_data", {24'h0, fifo_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_pending", {28'h0, pending}, 32'h0);
    check("rst_overflow", {28'h0, overflow}, 32'h0);
    reset = 1'b0;

    // Simultaneous strobes with rr_ptr at 0.
    cyc_q.delete();
    push_nonce(32'h11111111);
    push_nonce(32'h22222222);
    push_nonce(32'h33333333);
    strobe(4'b1101, at(0, 32'h11111111) | at(2, 32'h22222222) | at(3, 32'h33333333));
    check("sim_pending", {28'h0, pending}, 32'hD);
    wait_drain("sim");
    check_timing("sim", 12, 2, 15);

    // Table-driven single-nonce vectors into an idle block.
    for (int i = 0; i < 4; i++) begin
      cyc_q.delete();
      push_nonce(vt[i].nonce);
      strobe(4'(1 << vt[i].core), at(vt[i].core, vt[i].nonce));
      check("vec_pending_set", {28'h0, pending}, 32'(1 << vt[i].core));
      @(posedge hash_clk); #1;
      check("vec_pending_clr", {28'h0, pending}, 32'h0);
      check("vec_busy", {31'h0, busy}, 32'h1);
      wait_drain("vec");
      check_timing("vec", 4, 2, 5);
      check("vec_idle", {31'h0, busy}, 32'h0);
    end

    // Back-pressure after the second byte.
    base = bytes_seen;
    push_nonce(32'hA5A5_0F0F);
    strobe(4'b0001, at(0, 32'hA5A5_0F0F));
    wait_bytes(base + 2);
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_wr_en", {31'h0, fifo_wr_en}, 32'h0);
      check("bp_busy", {31'h0, busy}, 32'h1);
      @(posedge hash_clk); #1;
    end
    check("bp_stalled_bytes", bytes_seen - base, 2);
    fifo_full = 1'b0;
    wait_drain("bp");
    check("bp_total_bytes", bytes_seen - base, 4);

    // Overflow: second strobe on an occupied slot is dropped.
    push_nonce(32'h1234_5678);
    push_nonce(32'h0000_0001);
    strobe(4'b1000, at(3, 32'h1234_5678));
    strobe(4'b0001, at(0, 32'h0000_0001));
    strobe(4'b0001, at(0, 32'h0000_0002));
    check("ovf_flag", {28'h0, overflow}, 32'h1);
    wait_drain("ovf");
    check("ovf_sticky", {28'h0, overflow}, 32'h1);

    // Strobe in the very cycle slot 2 is granted.
    push_nonce(32'h0000_0004);
    push_nonce(32'h0000_0005);
    @(posedge hash_clk); #1;
    core_new_nonce = 4'b0100;
    core_golden_nonce = at(2, 32'h0000_0004);
    @(posedge hash_clk); #1;
    core_golden_nonce = at(2, 32'h0000_0005);
    @(posedge hash_clk); #1;
    core_new_nonce = '0;
    check("col_pending_reload", {28'h0, pending}, 32'h4);
    check("col_overflow", {28'h0, overflow}, 32'h1);
    wait_drain("col");
    check("col_overflow_after", {28'h0, overflow}, 32'h1);

    // Reset in the middle of a SEND, with another slot pending.
    base = bytes_seen;
    push_nonce(32'hCAFE_F00D);
    strobe(4'b0010, at(1, 32'hCAFE_F00D));
    strobe(4'b0100, at(2, 32'h9988_7766));
    wait_bytes(base + 2);
    reset = 1'b1;
    #1;
    check("mrst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_pending", {28'h0, pending}, 32'h0);
    check("mrst_overflow", {28'h0, overflow}, 32'h0);
    check("mrst_partial_bytes", bytes_seen - base, 2);
    sb.delete();
    repeat (2) @(posedge hash_clk);
    #1;
    reset = 1'b0;
    // rr_ptr back at 0 means core 1 is served before core 3.
    cyc_q.delete();
    push_nonce(32'h0BAD_F00D);
    push_nonce(32'h600D_CAFE);
    strobe(4'b1010, at(1, 32'h0BAD_F00D) | at(3, 32'h600D_CAFE));
    wait_drain("mrst");
    check_timing("mrst", 8, 2, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
